addsub_accum_seq: RTL

//  Multi-cycle accumulate sequencer around the shared 16-bit saturating adder/subtractor.
//  - Accepts a command: initial value, operand count, add/sub.
//  - Streams N operands through the adder, one per cycle, into a running accumulator.
//  - Returns the saturated total and a sticky saturation flag.
//  - Sits between the execute-stage control and the adder datapath.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_accum_seq_if.sv | 44 ++++
 rtl/addsub_accum_seq_adder.sv | 43 ++++
 rtl/addsub_accum_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the accumulate sequencer and its 16-bit saturating adder.
package addsub_pkg;

    localparam int DATA_W    = 16;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    // Clamp value for an overflow; the sign of the A operand tells the direction.
    function automatic logic [DATA_W-1:0] sat_limit(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/addsub_accum_seq_if.sv
// Command / operand / result handshake bundle for addsub_accum_seq.
// ovf_cnt is present only when ADDSUB_ACC_OVFCNT_EN is defined.
interface addsub_accum_seq_if
    import addsub_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    // Every channel transfers on a rising clk edge where its valid and ready are both 1;
    // ready never depends combinationally on valid, and valid is held until the transfer.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_len;
    logic              cmd_sub;
    logic [DATA_W-1:0] cmd_init;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_sat;
    logic              busy;
    state_e            state_dbg;
`ifdef ADDSUB_ACC_OVFCNT_EN
    logic [CNT_W:0]    ovf_cnt;
`endif

    modport master (
        output cmd_valid, cmd_len, cmd_sub, cmd_init, op_valid, op_data, res_ready,
`ifdef ADDSUB_ACC_OVFCNT_EN
        input  ovf_cnt,
`endif
        input  cmd_ready, op_ready, res_valid, res_data, res_sat, busy, state_dbg
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_sub, cmd_init, op_valid, op_data, res_ready,
`ifdef ADDSUB_ACC_OVFCNT_EN
        output ovf_cnt,
`endif
        output cmd_ready, op_ready, res_valid, res_data, res_sat, busy, state_dbg
    );

endinterface

// File: rtl/addsub_accum_seq_adder.sv
// 16-bit carry-lookahead adder with signed saturation; subtraction is done by the caller
// inverting B and driving sub as the carry-in.
module CLA_addsub_16
    import addsub_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        ovfl
);

    always_comb begin
        logic [15:0] g;
        logic [15:0] p;
        logic [16:0] c;
        logic [3:0]  gg;
        logic [3:0]  pp;
        logic [15:0] raw;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gg    = '0;
        pp    = '0;
        c[0]  = sub;
        // Four 4-bit lookahead groups; group carry-out comes from group G/P.
        for (int k = 0; k < 4; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pp[k]    = &p[4*k +: 4];
            c[4*k+4] = gg[k] | (pp[k] & c[4*k]);
        end
        raw  = p ^ c[15:0];
        // Signed overflow iff carry into and out of the sign bit differ.
        ovfl = c[16] ^ c[15];
        sum  = ovfl ? sat_limit(a[15]) : raw;
    end

endmodule

// File: rtl/addsub_accum_seq.sv
// Accumulate sequencer: loads a command, streams N operands through the saturating adder,
// returns the total with a sticky saturation flag. Optional ADDSUB_ACC_OVFCNT_EN adds ovf_cnt.
module addsub_accum_seq
    import addsub_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_accum_seq_if.slave  bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sub_q, sub_d;
    logic              sat_q, sat_d;
`ifdef ADDSUB_ACC_OVFCNT_EN
    logic [CNT_W:0]    ovf_q, ovf_d;
`endif

    logic              cmd_ready;
    logic              op_ready;
    logic              res_valid;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovfl;

    assign add_b = sub_q ? ~bus.op_data : bus.op_data;

    CLA_addsub_16 u_adder (
        .a    (acc_q),
        .b    (add_b),
        .sub  (sub_q),
        .sum  (add_sum),
        .ovfl (add_ovfl)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        sat_d     = sat_q;
`ifdef ADDSUB_ACC_OVFCNT_EN
        ovf_d     = ovf_q;
`endif
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    acc_d   = bus.cmd_init;
                    cnt_d   = bus.cmd_len;
                    sub_d   = bus.cmd_sub;
                    sat_d   = 1'b0;
`ifdef ADDSUB_ACC_OVFCNT_EN
                    ovf_d   = '0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                op_ready = 1'b1;
                if (bus.op_valid) begin
                    acc_d = add_sum;
                    sat_d = sat_q | add_ovfl;
                    cnt_d = cnt_q - 1'b1;
`ifdef ADDSUB_ACC_OVFCNT_EN
                    ovf_d = ovf_q + {{CNT_W{1'b0}}, add_ovfl};
`endif
                    // cnt holds operands remaining minus one, so zero marks the last one.
                    if (cnt_q == '0) state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            sat_q   <= 1'b0;
`ifdef ADDSUB_ACC_OVFCNT_EN
            ovf_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            sat_q   <= sat_d;
`ifdef ADDSUB_ACC_OVFCNT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.op_ready  = op_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = acc_q;
    assign bus.res_sat   = sat_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;
`ifdef ADDSUB_ACC_OVFCNT_EN
    assign bus.ovf_cnt   = ovf_q;
`endif

endmodule
